fetch_stage: RTL and testbench



---
 rtl/fetch_stage_if.sv | 24 ++
 rtl/fetch_stage.sv | 142 ++++++++++++++
 tb/tb_fetch_stage.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/grant/response bundle between fetch_stage and imem.
interface fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID register; one outstanding imem request.
// Define FETCH_SKID_BUFFER_EN to keep a response that arrives under stall.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 stall,
  input  logic                 redirect,
  input  logic [31:0]          redirect_pc,
  fetch_stage_if.master        imem,
  output logic [31:0]          instruction,
  output logic [31:0]          pc,
  output logic                 instr_valid
);

`ifdef FETCH_SKID_BUFFER_EN
  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;
  logic [31:0] buf_q, buf_d;
`else
  typedef enum logic [1:0] {S_REQ, S_WAIT} state_t;
`endif

  state_t      state_q, state_d;
  logic [31:0] pc_fetch_q, pc_fetch_d;
  logic        kill_q, kill_d;
  logic [31:0] instr_q, ifid_pc_q;
  logic        valid_q;
  logic        load;
  logic [31:0] load_instr;
  logic        unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  assign imem.imem_req  = (state_q == S_REQ);
  assign imem.imem_addr = pc_fetch_q;
  assign instruction    = instr_q;
  assign pc             = ifid_pc_q;
  assign instr_valid    = valid_q;

  always_comb begin
    state_d    = state_q;
    pc_fetch_d = pc_fetch_q;
    kill_d     = kill_q;
    load       = 1'b0;
    load_instr = imem.imem_rdata;
`ifdef FETCH_SKID_BUFFER_EN
    buf_d      = buf_q;
`endif
    case (state_q)
      S_REQ: begin
        if (imem.imem_gnt) begin
          state_d = S_WAIT;
          // A grant coinciding with redirect fetches the stale address; drop it.
          kill_d  = redirect;
        end
      end
      S_WAIT: begin
        if (imem.imem_rvalid) begin
          if (kill_q || redirect) begin
            kill_d  = 1'b0;
            state_d = S_REQ;
          end else if (!stall) begin
            load       = 1'b1;
            pc_fetch_d = pc_fetch_q + 32'd4;
            state_d    = S_REQ;
          end else begin
`ifdef FETCH_SKID_BUFFER_EN
            buf_d   = imem.imem_rdata;
            state_d = S_HOLD;
`else
            state_d = S_REQ;
`endif
          end
        end else if (redirect) begin
          kill_d = 1'b1;
        end
      end
`ifdef FETCH_SKID_BUFFER_EN
      S_HOLD: begin
        if (redirect) begin
          state_d = S_REQ;
        end else if (!stall) begin
          load       = 1'b1;
          load_instr = buf_q;
          pc_fetch_d = pc_fetch_q + 32'd4;
          state_d    = S_REQ;
        end
      end
`endif
      default: begin
        state_d = S_REQ;
        kill_d  = 1'b0;
      end
    endcase
    if (redirect) pc_fetch_d = {redirect_pc[31:2], 2'b00};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_REQ;
      pc_fetch_q <= RESET_PC;
      kill_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_fetch_q <= pc_fetch_d;
      kill_q     <= kill_d;
    end
  end

`ifdef FETCH_SKID_BUFFER_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) buf_q <= '0;
    else        buf_q <= buf_d;
  end
`endif

  // Bubbles keep the last PC; only instruction and valid are scrubbed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q   <= NOP_INSTR;
      ifid_pc_q <= '0;
      valid_q   <= 1'b0;
    end else if (redirect) begin
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
    end else if (stall) begin
      instr_q   <= instr_q;
      ifid_pc_q <= ifid_pc_q;
      valid_q   <= valid_q;
    end else if (load) begin
      instr_q   <= load_instr;
      ifid_pc_q <= pc_fetch_q;
      valid_q   <= 1'b1;
    end else begin
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed per-cycle vector bench for fetch_stage, plus an async-reset sequence.
module tb_fetch_stage;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] instruction;
  logic [31:0] pc;
  logic        instr_valid;

  fetch_stage_if bus ();

  fetch_stage #(
    .RESET_PC  (32'h0000_0000),
    .NOP_INSTR (NOP)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem        (bus.master),
    .instruction (instruction),
    .pc          (pc),
    .instr_valid (instr_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        redir;
    logic [31:0] rpc;
    logic        gnt;
    logic        rv;
    logic [31:0] rdata;
    logic        ereq;
    logic [31:0] eaddr;
    logic [31:0] einstr;
    logic [31:0] epc;
    logic        evalid;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  function automatic void add(logic st, logic rd, logic [31:0] rpc, logic gnt, logic rv,
                              logic [31:0] rdata, logic ereq, logic [31:0] eaddr,
                              logic [31:0] einstr, logic [31:0] epc, logic evalid);
    vec_t v;
    v.stall = st; v.redir = rd; v.rpc = rpc; v.gnt = gnt; v.rv = rv; v.rdata = rdata;
    v.ereq = ereq; v.eaddr = eaddr; v.einstr = einstr; v.epc = epc; v.evalid = evalid;
    vecs.push_back(v);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic chk_all(string tag, logic ereq, logic [31:0] eaddr, logic [31:0] einstr,
                         logic [31:0] epc, logic evalid);
    chk({tag, " req"},   {31'd0, bus.imem_req}, {31'd0, ereq});
    chk({tag, " addr"},  bus.imem_addr, eaddr);
    chk({tag, " instr"}, instruction, einstr);
    chk({tag, " pc"},    pc, epc);
    chk({tag, " valid"}, {31'd0, instr_valid}, {31'd0, evalid});
  endtask

  task automatic drive(logic st, logic rd, logic [31:0] rpc, logic gnt, logic rv, logic [31:0] rdata);
    stall = st; redirect = rd; redirect_pc = rpc;
    bus.imem_gnt = gnt; bus.imem_rvalid = rv; bus.imem_rdata = rdata;
  endtask

  initial begin
    // stall, redirect, redirect_pc, gnt, rvalid, rdata | req, addr, instruction, pc, valid
    add(0,0,0,1,0,0,                              1,32'h0,NOP,0,0);
    add(0,0,0,0,1,32'h0050_0093,                  0,32'h0,NOP,0,0);
    add(0,0,0,0,0,0,                              1,32'h4,32'h0050_0093,0,1);
    add(0,0,0,0,0,0,                              1,32'h4,NOP,0,0);
    add(0,0,0,0,1,32'hDEAD_BEEF,                  1,32'h4,NOP,0,0);
    add(0,0,0,0,0,0,                              1,32'h4,NOP,0,0);
    add(0,0,0,1,0,0,                              1,32'h4,NOP,0,0);
    add(0,0,0,0,1,32'h0010_0113,                  0,32'h4,NOP,0,0);
    add(0,0,0,1,0,0,                              1,32'h8,32'h0010_0113,32'h4,1);
    add(0,1,32'h103,0,0,0,                        0,32'h8,NOP,32'h4,0);
    add(0,0,0,0,1,32'hBAD0_0013,                  0,32'h100,NOP,32'h4,0);
    add(0,0,0,1,0,0,                              1,32'h100,NOP,32'h4,0);
    add(0,0,0,0,1,32'h0030_0193,                  0,32'h100,NOP,32'h4,0);
    add(0,1,32'hFFFF_FFFC,0,0,0,                  1,32'h104,32'h0030_0193,32'h100,1);
    add(0,0,0,1,0,0,                              1,32'hFFFF_FFFC,NOP,32'h100,0);
    add(0,0,0,0,1,32'h0040_0213,                  0,32'hFFFF_FFFC,NOP,32'h100,0);
    add(0,0,0,1,0,0,                              1,32'h0,32'h0040_0213,32'hFFFF_FFFC,1);
    add(0,0,0,0,1,32'h0050_0093,                  0,32'h0,NOP,32'hFFFF_FFFC,0);
    add(0,1,32'h6,1,0,0,                          1,32'h4,32'h0050_0093,32'h0,1);
    add(0,0,0,0,1,32'hBAD0_0013,                  0,32'h4,NOP,32'h0,0);
    add(0,0,0,1,0,0,                              1,32'h4,NOP,32'h0,0);
    add(0,0,0,0,1,32'h0010_0113,                  0,32'h4,NOP,32'h0,0);
    add(1,0,0,1,0,0,                              1,32'h8,32'h0010_0113,32'h4,1);
    add(1,0,0,0,1,32'h0020_8133,                  0,32'h8,32'h0010_0113,32'h4,1);
`ifdef FETCH_SKID_BUFFER_EN
    add(1,0,0,0,0,0,                              0,32'h8,32'h0010_0113,32'h4,1);
    add(0,0,0,1,0,0,                              0,32'h8,32'h0010_0113,32'h4,1);
    add(0,0,0,0,0,0,                              1,32'hC,32'h0020_8133,32'h8,1);
`else
    add(1,0,0,0,0,0,                              1,32'h8,32'h0010_0113,32'h4,1);
    add(0,0,0,1,0,0,                              1,32'h8,32'h0010_0113,32'h4,1);
    add(0,0,0,0,1,32'h0020_8133,                  0,32'h8,NOP,32'h4,0);
    add(0,0,0,0,0,0,                              1,32'hC,32'h0020_8133,32'h8,1);
`endif

    rst_n = 1'b0;
    drive(0, 0, 32'h0, 0, 0, 32'h0);
    @(negedge clk);
    @(negedge clk);
    #1 chk_all("reset", 1'b1, 32'h0, NOP, 32'h0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].stall, vecs[i].redir, vecs[i].rpc, vecs[i].gnt, vecs[i].rv, vecs[i].rdata);
      #1 chk_all($sformatf("row%0d", i), vecs[i].ereq, vecs[i].eaddr, vecs[i].einstr,
                 vecs[i].epc, vecs[i].evalid);
      @(negedge clk);
    end

    // Async reset while a request is outstanding, then a late response.
    drive(0, 0, 32'h0, 1, 0, 32'h0);
    #1 chk("rs grant addr", bus.imem_addr, 32'hC);
    @(negedge clk);
    drive(0, 0, 32'h0, 0, 1, 32'h0060_0313);
    #1 chk("rs wait req", {31'd0, bus.imem_req}, 32'd0);
    @(negedge clk);
    drive(0, 0, 32'h0, 1, 0, 32'h0);
    #1 chk_all("rs loaded", 1'b1, 32'h10, 32'h0060_0313, 32'hC, 1'b1);
    @(negedge clk);
    drive(0, 0, 32'h0, 0, 0, 32'h0);
    #1 chk("rs pre req", {31'd0, bus.imem_req}, 32'd0);
    #1 rst_n = 1'b0;
    #1 chk_all("rs async", 1'b1, 32'h0, NOP, 32'h0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 0, 32'h0, 0, 1, 32'hDEAD_0013);
    #1 chk_all("rs late", 1'b1, 32'h0, NOP, 32'h0, 1'b0);
    @(negedge clk);
    drive(0, 0, 32'h0, 1, 0, 32'h0);
    #1 chk_all("rs ignored", 1'b1, 32'h0, NOP, 32'h0, 1'b0);
    @(negedge clk);
    drive(0, 0, 32'h0, 0, 1, 32'h0070_0393);
    #1 chk("rs refetch req", {31'd0, bus.imem_req}, 32'd0);
    @(negedge clk);
    drive(0, 0, 32'h0, 0, 0, 32'h0);
    #1 chk_all("rs refetch", 1'b1, 32'h4, 32'h0070_0393, 32'h0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
